// File: rtl/spi_reg_slave_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_reg_slave_pkg;

    localparam int REG_COUNT    = 16;
    localparam int ADDR_W       = 4;
    localparam int DATA_W       = 8;
    localparam int CMD_READ_BIT = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_state_e;

    // Burst address step; wraps naturally at the top of the register file.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus rise/fall detection
// on the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;

    // Synchronizer chain and one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= {STAGES{IDLE_VAL}};
            prev_q  <= IDLE_VAL;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
            prev_q  <= chain_q[STAGES-1];
        end
    end

    assign q_o    = chain_q[STAGES-1];
    assign rise_o = chain_q[STAGES-1] & ~prev_q;
    assign fall_o = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave exposing 16 x 8-bit registers: command byte (R/W + start
// address) followed by auto-incrementing data bytes.
module spi_reg_slave
    import spi_reg_slave_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  RESET_VAL   = 8'h00
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              nCS,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_rdata,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    logic ncs_s, sck_rise_s, sck_fall_s, mosi_s;
    logic unused_ncs_rise_s, unused_ncs_fall_s, unused_sck_lvl_s;
    logic unused_mosi_rise_s, unused_mosi_fall_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_ncs (
        .clk_i(CLK), .rst_i(RST), .d_i(nCS),
        .q_o(ncs_s), .rise_o(unused_ncs_rise_s), .fall_o(unused_ncs_fall_s)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sck (
        .clk_i(CLK), .rst_i(RST), .d_i(SCK),
        .q_o(unused_sck_lvl_s), .rise_o(sck_rise_s), .fall_o(sck_fall_s)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
        .clk_i(CLK), .rst_i(RST), .d_i(MOSI),
        .q_o(mosi_s), .rise_o(unused_mosi_rise_s), .fall_o(unused_mosi_fall_s)
    );

    spi_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_in_q, shift_in_d;
    logic [DATA_W-1:0] shift_out_q, shift_out_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] rx_byte_s;
    logic              reg_we_s;
    logic [1:0]        settle_q;
    logic              armed_q;

    // The nCS chain starts at its idle level, so a low nCS at reset release
    // would look like a fresh select; only arm once a real high has been seen.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            settle_q <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != SYNC_STAGES[1:0]) settle_q <= settle_q + 2'd1;
            else                              settle_q <= settle_q;
            if ((settle_q == SYNC_STAGES[1:0]) && ncs_s) armed_q <= 1'b1;
            else                                         armed_q <= armed_q;
        end
    end

    // Next-state and datapath logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        reg_we_s    = 1'b0;
        rx_byte_s   = {shift_in_q[DATA_W-2:0], mosi_s};
        if (ncs_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d    = ST_CMD;
                        bit_cnt_d  = 3'd0;
                        shift_in_d = {DATA_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD, ST_DATA: begin
                    if (sck_rise_s) begin
                        shift_in_d = rx_byte_s;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_CMD) begin
                                state_d     = ST_DATA;
                                addr_d      = rx_byte_s[ADDR_W-1:0];
                                rd_d        = rx_byte_s[CMD_READ_BIT];
                                shift_out_d = regs_q[rx_byte_s[ADDR_W-1:0]];
                            end else begin
                                addr_d      = next_addr(addr_q);
                                shift_out_d = regs_q[next_addr(addr_q)];
                                if (!rd_q) begin
                                    reg_we_s   = 1'b1;
                                    wr_pulse_d = 1'b1;
                                    wr_addr_d  = addr_q;
                                    wr_data_d  = rx_byte_s;
                                end else begin
                                    reg_we_s = 1'b0;
                                end
                            end
                        end else begin
                            shift_out_d = shift_out_q;
                        end
                    end else if (sck_fall_s && (bit_cnt_q != 3'd0)) begin
                        // The fall right after a byte boundary keeps the freshly loaded MSB.
                        shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
                    end else begin
                        shift_out_d = shift_out_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= {DATA_W{1'b0}};
            shift_out_q <= {DATA_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
            rd_q        <= 1'b0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= {ADDR_W{1'b0}};
            wr_data_q   <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Register file; written in the same edge that raises wr_pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= RESET_VAL;
        end else if (reg_we_s) begin
            regs_q[addr_q] <= rx_byte_s;
        end
    end

    assign host_rdata = regs_q[host_addr];
    assign MISO_OE    = ~ncs_s & (state_q == ST_DATA) & rd_q;
    assign MISO       = MISO_OE & shift_out_q[DATA_W-1];
    assign wr_pulse   = wr_pulse_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = ~ncs_s;

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for nCS/SCK/MOSI (legal 2..3).
REQ-002 SHALL have parameter RESET_VAL, default 8'h00, reset contents of every register.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 CLK  input  1  system clock; all state on rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 nCS  input  1  SPI chip select, active low, asynchronous to CLK.
REQ-007 SCK  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to CLK.
REQ-008 MOSI  input  1  SPI data in, MSB first.
REQ-009 MISO  output  1  SPI data out, MSB first.
REQ-010 MISO_OE  output  1  MISO drive enable; the enclosing module drives pin as MISO_OE ? MISO : 1'bz.
REQ-011 host_addr  input  4  fabric-side read address.
REQ-012 host_rdata  output  8  combinational read of reg[host_addr].
REQ-013 wr_pulse  output  1  one-CLK pulse per completed SPI register write.
REQ-014 wr_addr  output  4  address of the write flagged by wr_pulse.
REQ-015 wr_data  output  8  data of the write flagged by wr_pulse.
REQ-016 busy  output  1  high while a transaction is in progress (synchronized nCS low).

Function
REQ-017 SHALL hold 16 x 8-bit registers.
REQ-018 SHALL synchronize nCS, SCK, MOSI through SYNC_STAGES flops; edges detected on synchronized SCK only.
REQ-019 SHALL operate correctly for SCK period >= 8 CLK periods and SCK high/low each >= 3 CLK periods.
REQ-020 SHALL sample MOSI on SCK rising edge and update MISO on SCK falling edge.
REQ-021 FSM states: IDLE, CMD, DATA; IDLE->CMD on synchronized nCS falling; CMD->DATA after 8th bit; DATA->DATA each byte; any state->IDLE on synchronized nCS high.
REQ-022 Command byte: bit7 = 1 read, 0 write; bits6:4 ignored; bits3:0 start address.
REQ-023 Write: each complete data byte SHALL be stored to reg[addr] within 2 CLK of its 8th SCK rising edge, with wr_pulse=1 for exactly one CLK and wr_addr/wr_data valid in that cycle.
REQ-024 Read: reg[addr] SHALL be loaded into the shift register within 2 CLK of the command byte's 8th SCK rising edge and its MSB presented on MISO before the next SCK rising edge; subsequent bits on each falling edge.
REQ-025 Burst: address SHALL increment after each data byte, wrapping 15->0.
REQ-026 Read bursts SHALL load the next register at each byte boundary, same timing as REQ-024.
REQ-027 MISO_OE SHALL equal synchronized nCS low AND state==DATA AND read command; MISO=0 otherwise.
REQ-028 nCS rising mid-byte SHALL discard the partial byte: no register write, no wr_pulse, bit counter cleared.
REQ-029 Fabric read via host_rdata during an SPI write to the same address SHALL return old value until the write cycle, new value after.
REQ-030 busy SHALL follow synchronized nCS (inverted), no further latency.

Reset
REQ-031 On RST: all registers=RESET_VAL, FSM=IDLE, bit counter=0, shift registers=0, synchronizers=idle levels (nCS=1, SCK=0, MOSI=0).
REQ-032 On RST: MISO=0, MISO_OE=0, wr_pulse=0, wr_addr=0, wr_data=0, busy=0.
REQ-033 After RST release with nCS already low, SHALL stay IDLE until nCS goes high then low again.

Structure
REQ-034 Shared package SHALL hold FSM state enumeration, REG_COUNT=16, ADDR_W=4, DATA_W=8, CMD_READ_BIT=7.
REQ-035 One sub-module spi_sync_edge SHALL implement the synchronizer chain and rise/fall detect, instanced per input.

Verification
REQ-036 Write 0x05,0xA5 (nCS framed) -> reg[5]=0xA5; one wr_pulse with wr_addr=5, wr_data=0xA5.
REQ-037 After REQ-036, send 0x85,0x00 -> MISO shifts 1010_0101 in byte 2; MISO_OE high only during byte 2.
REQ-038 Burst write 0x0F,0x11,0x22 -> reg[15]=0x11, reg[0]=0x22 (wrap); two wr_pulses.
REQ-039 Write 0x03 then 4 data bits, nCS high -> reg[3] unchanged, no wr_pulse; next full transaction correct.
REQ-040 Assert RST mid-burst-read -> all outputs at reset values within 1 CLK; all registers read RESET_VAL via host_rdata.
REQ-041 SCK at exactly 8 CLK period, 3 CLK minimum high time, write/read-back of all 16 registers with random data -> all match.
